// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way write-back cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Derived widths: word offset, set index, tag, block.
    function automatic int off_w(input int wpb);
        return clog2(wpb);
    endfunction

    function automatic int idx_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int wpb, input int sets);
        return addr_w - clog2(wpb) - clog2(sets);
    endfunction

    function automatic int blk_w(input int wpb, input int word_w);
        return wpb * word_w;
    endfunction

    // Way/age index width; a direct-mapped build still needs one bit.
    function automatic int way_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/nway_lru.sv
// Per-set true-LRU ages: touch update and victim select (invalid way first, then oldest).
module nway_lru
    import cache_pkg::*;
#(
    parameter int SETS = 32,
    parameter int WAYS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [idx_w(SETS)-1:0]   set_idx,
    input  logic [WAYS-1:0]          valid_vec,
    input  logic                     touch_en,
    input  logic [way_w(WAYS)-1:0]   touch_way,
    output logic [way_w(WAYS)-1:0]   victim
);
    localparam int IDX_W = idx_w(SETS);
    localparam int AGE_W = way_w(WAYS);

    logic [AGE_W-1:0] age_q [SETS][WAYS];

    // Age update: the touched way becomes youngest, younger ways age by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= AGE_W'(w);
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way)
                    age_q[set_idx][w] <= '0;
                else if (age_q[set_idx][w] < age_q[set_idx][touch_way])
                    age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the way holding the oldest age.
    always_comb begin
        logic found;
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_vec[w]) begin
                victim = AGE_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[set_idx][w] == AGE_W'(WAYS - 1))
                    victim = AGE_W'(w);
            end
        end
    end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back cache with true-LRU replacement.
// Hits complete combinationally; misses write back a dirty victim, then fill.
// Optional hit/miss statistics: define NWAY_WB_CACHE_STATS_EN.
module nway_wb_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int WPB    = 4,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic                            cpu_re,
    input  logic                            cpu_we,
    input  logic [WORD_W-1:0]               cpu_wr_data,
    output logic [WORD_W-1:0]               cpu_rd_data,
    output logic                            cpu_rdy,
    output logic [ADDR_W-off_w(WPB)-1:0]    m_addr,
    output logic                            m_re,
    output logic                            m_we,
    output logic [WPB*WORD_W-1:0]           m_wr_data,
    input  logic [WPB*WORD_W-1:0]           m_rd_data,
    input  logic                            m_rdy,
    output logic [15:0]                     hit_cnt,
    output logic [15:0]                     miss_cnt
);
    localparam int OFF_W = off_w(WPB);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, WPB, SETS);
    localparam int BLK_W = blk_w(WPB, WORD_W);
    localparam int WAY_W = way_w(WAYS);

    cache_state_t state, next_state;

    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [BLK_W-1:0] data_mem [WAYS][SETS];
    logic [SETS-1:0]  valid_q  [WAYS];
    logic [SETS-1:0]  dirty_q  [WAYS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req;
    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  valid_set;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             victim_dirty;
    logic [BLK_W-1:0] hit_blk;

    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic [WAY_W-1:0] vic_q;

    assign req_off = cpu_addr[OFF_W-1:0];
    assign req_idx = cpu_addr[OFF_W +: IDX_W];
    assign req_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req     = cpu_re | cpu_we;

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_set[w] = valid_q[w][req_idx];
            hit_vec[w]   = valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit          = |hit_vec;
    assign hit_blk      = data_mem[hit_way][req_idx];
    assign cpu_rd_data  = hit_blk[req_off*WORD_W +: WORD_W];
    assign cpu_rdy      = (state == IDLE) && req && hit;
    assign victim_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];

    nway_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_idx   (req_idx),
        .valid_vec (valid_set),
        .touch_en  (cpu_rdy),
        .touch_way (hit_way),
        .victim    (victim)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: a miss goes through write-back only when the victim is dirty.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req && !hit) next_state = victim_dirty ? WRITEBACK : FILL;
            WRITEBACK: if (m_rdy) next_state = FILL;
            FILL:      if (m_rdy) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Registered memory-port controls and miss context latched at the miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_re    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            lat_idx <= '0;
            lat_tag <= '0;
            vic_q   <= '0;
        end else begin
            m_re <= (next_state == FILL);
            m_we <= (next_state == WRITEBACK);
            if (state == IDLE && req && !hit) begin
                lat_idx <= req_idx;
                lat_tag <= req_tag;
                vic_q   <= victim;
                if (victim_dirty) m_addr <= {tag_mem[victim][req_idx], req_idx};
                else              m_addr <= {req_tag, req_idx};
            end else if (state == WRITEBACK && m_rdy) begin
                m_addr <= {lat_tag, lat_idx};
            end
        end
    end

    // Victim block snapshot for write-back; contents are don't-care until used.
    always_ff @(posedge clk) begin
        if (state == IDLE && req && !hit && victim_dirty)
            m_wr_data <= data_mem[victim][req_idx];
    end

    // Tag/data arrays: word write on hit, whole-line install on fill.
    always_ff @(posedge clk) begin
        if (cpu_rdy && cpu_we)
            data_mem[hit_way][req_idx][req_off*WORD_W +: WORD_W] <= cpu_wr_data;
        if (state == FILL && m_rdy) begin
            data_mem[vic_q][lat_idx] <= m_rd_data;
            tag_mem[vic_q][lat_idx]  <= lat_tag;
        end
    end

    // Valid/dirty bits: cleared by reset so a mid-miss reset drops every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            if (cpu_rdy && cpu_we)
                dirty_q[hit_way][req_idx] <= 1'b1;
            if (state == FILL && m_rdy) begin
                valid_q[vic_q][lat_idx] <= 1'b1;
                dirty_q[vic_q][lat_idx] <= 1'b0;
            end
        end
    end

`ifdef NWAY_WB_CACHE_STATS_EN
    logic [15:0] hit_q, miss_q;

    // Saturating hit/miss counters; a retried hit after a fill counts as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (cpu_rdy && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (state == IDLE && next_state != IDLE && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_nway_wb_cache.sv
// Directed bench for nway_wb_cache with a fixed-latency block memory model.
module tb_nway_wb_cache;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_wr_data = '0;
    logic [15:0] cpu_rd_data;
    logic        cpu_rdy;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_wr_data;
    logic [63:0] m_rd_data;
    logic        m_rdy;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int tests = 0;
    int fails = 0;

    // Memory model log.
    logic [63:0] mem_store [int];
    int          n_wr = 0;
    int          n_rd = 0;
    int          seq = 0;
    int          wr_seq = 0;
    int          rd_seq = 0;
    logic [13:0] wr_addr = '0;
    logic [13:0] rd_addr = '0;
    logic [63:0] wr_data = '0;
    int          mcnt = 0;

    nway_wb_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_re      (cpu_re),
        .cpu_we      (cpu_we),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_data (cpu_rd_data),
        .cpu_rdy     (cpu_rdy),
        .m_addr      (m_addr),
        .m_re        (m_re),
        .m_we        (m_we),
        .m_wr_data   (m_wr_data),
        .m_rd_data   (m_rd_data),
        .m_rdy       (m_rdy),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_default(input logic [13:0] b);
        logic [63:0] d;
        if (b == 14'h0010) return 64'h0004_0003_0002_0001;
        for (int i = 0; i < 4; i++) d[i*16 +: 16] = {b[11:0], 4'(i)};
        return d;
    endfunction

    // Memory responder: LAT wait cycles, then one m_rdy cycle.
    initial begin
        m_rdy = 1'b0;
        m_rd_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rdy = 1'b0;
                mcnt = 0;
            end else if (m_rdy) begin
                m_rdy = 1'b0;
            end else if (m_we || m_re) begin
                if (mcnt == LAT) begin
                    mcnt = 0;
                    m_rdy = 1'b1;
                    seq++;
                    if (m_we) begin
                        n_wr++;
                        wr_addr = m_addr;
                        wr_data = m_wr_data;
                        wr_seq = seq;
                        mem_store[int'(m_addr)] = m_wr_data;
                    end else begin
                        n_rd++;
                        rd_addr = m_addr;
                        rd_seq = seq;
                        m_rd_data = mem_store.exists(int'(m_addr)) ? mem_store[int'(m_addr)]
                                                                   : mem_default(m_addr);
                    end
                end else begin
                    mcnt++;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One CPU request held until cpu_rdy; cyc = cycles after the request cycle.
    task automatic cpu_access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                              output logic [15:0] rd, output int cyc);
        @(negedge clk);
        cpu_addr = a;
        cpu_we = we;
        cpu_re = !we;
        cpu_wr_data = wd;
        cyc = 0;
        #1;
        while (!cpu_rdy && cyc < 200) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        tests++;
        if (!cpu_rdy) begin
            fails++;
            $display("FAIL timeout addr=%h: cpu_rdy never rose within %0d cycles", a, cyc);
        end
        rd = cpu_rd_data;
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic check_stats(input string name, input logic [15:0] eh, input logic [15:0] em);
`ifndef NWAY_WB_CACHE_STATS_EN
        eh = 16'd0;
        em = 16'd0;
`endif
        #1;
        tests++;
        if (hit_cnt !== eh) begin
            fails++;
            $display("FAIL %s hit_cnt: got %h expected %h", name, hit_cnt, eh);
        end
        tests++;
        if (miss_cnt !== em) begin
            fails++;
            $display("FAIL %s miss_cnt: got %h expected %h", name, miss_cnt, em);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if (m_re !== 1'b0 || m_we !== 1'b0 || cpu_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: m_re=%b m_we=%b cpu_rdy=%b expected 0 0 0", m_re, m_we, cpu_rdy);
        end
        check_stats("reset", 16'd0, 16'd0);
    endtask

    task automatic test_clean_miss();
        logic [15:0] rd;
        int cyc;
        cpu_access(16'h0040, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (cyc != 6) begin
            fails++;
            $display("FAIL clean_miss_latency: got %0d expected 6", cyc);
        end
        tests++;
        if (rd !== 16'h0001) begin
            fails++;
            $display("FAIL clean_miss_data: got %h expected 0001", rd);
        end
        tests++;
        if (n_rd != 1 || rd_addr !== 14'h0010 || n_wr != 0) begin
            fails++;
            $display("FAIL clean_miss_mem: reads=%0d addr=%h writes=%0d expected 1 0010 0", n_rd, rd_addr, n_wr);
        end
        check_stats("clean_miss", 16'd1, 16'd1);
    endtask

    task automatic test_write_hit();
        logic [15:0] rd;
        int cyc;
        int nr, nw;
        nr = n_rd;
        nw = n_wr;
        cpu_access(16'h0041, 1'b1, 16'hBEEF, rd, cyc);
        tests++;
        if (cyc != 0) begin
            fails++;
            $display("FAIL write_hit_latency: got %0d expected 0", cyc);
        end
        cpu_access(16'h0041, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (cyc != 0 || rd !== 16'hBEEF) begin
            fails++;
            $display("FAIL read_after_write: cyc=%0d data=%h expected 0 BEEF", cyc, rd);
        end
        tests++;
        if (n_rd != nr || n_wr != nw || m_re !== 1'b0 || m_we !== 1'b0) begin
            fails++;
            $display("FAIL hit_mem_quiet: reads=%0d writes=%0d expected %0d %0d", n_rd, n_wr, nr, nw);
        end
        check_stats("write_hit", 16'd3, 16'd1);
    endtask

    task automatic test_dirty_evict();
        logic [15:0] rd;
        int cyc;
        cpu_access(16'h00C0, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (cyc != 6 || rd !== 16'h0300 || n_wr != 0) begin
            fails++;
            $display("FAIL fill_second_way: cyc=%0d data=%h writes=%0d expected 6 0300 0", cyc, rd, n_wr);
        end
        cpu_access(16'h0140, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (n_wr != 1 || wr_addr !== 14'h0010 || wr_data !== 64'h0004_0003_BEEF_0001) begin
            fails++;
            $display("FAIL dirty_writeback: writes=%0d addr=%h data=%h expected 1 0010 00040003beef0001",
                     n_wr, wr_addr, wr_data);
        end
        tests++;
        if (rd_addr !== 14'h0050 || rd_seq <= wr_seq) begin
            fails++;
            $display("FAIL fill_after_wb: addr=%h rd_seq=%0d wr_seq=%0d expected 0050 and fill after write-back",
                     rd_addr, rd_seq, wr_seq);
        end
        tests++;
        if (cyc != 12 || rd !== 16'h0500) begin
            fails++;
            $display("FAIL dirty_miss_hit: cyc=%0d data=%h expected 12 0500", cyc, rd);
        end
        check_stats("dirty_evict", 16'd5, 16'd3);
    endtask

    task automatic test_clean_evict();
        logic [15:0] rd;
        int cyc;
        int nw, nr;
        apply_reset();
        check_stats("clean_evict_reset", 16'd0, 16'd0);
        cpu_access(16'h0040, 1'b0, 16'h0, rd, cyc);
        cpu_access(16'h0041, 1'b1, 16'hBEEF, rd, cyc);
        cpu_access(16'h00C0, 1'b0, 16'h0, rd, cyc);
        cpu_access(16'h0040, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (cyc != 0 || rd !== 16'h0001) begin
            fails++;
            $display("FAIL touch_hit: cyc=%0d data=%h expected 0 0001", cyc, rd);
        end
        nw = n_wr;
        nr = n_rd;
        cpu_access(16'h0140, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (n_wr != nw || n_rd != nr + 1 || rd_addr !== 14'h0050) begin
            fails++;
            $display("FAIL clean_victim: new_writes=%0d new_reads=%0d addr=%h expected 0 1 0050",
                     n_wr - nw, n_rd - nr, rd_addr);
        end
        tests++;
        if (cyc != 6) begin
            fails++;
            $display("FAIL clean_victim_latency: got %0d expected 6", cyc);
        end
        cpu_access(16'h0041, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (cyc != 0 || rd !== 16'hBEEF) begin
            fails++;
            $display("FAIL dirty_line_kept: cyc=%0d data=%h expected 0 BEEF", cyc, rd);
        end
        check_stats("clean_evict", 16'd6, 16'd3);
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] rd;
        int cyc;
        int k;
        int nr;
        apply_reset();
        cpu_access(16'h0040, 1'b0, 16'h0, rd, cyc);
        apply_reset();
        @(negedge clk);
        cpu_addr = 16'h0040;
        cpu_re = 1'b1;
        k = 0;
        while (!m_re && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (!m_re) begin
            fails++;
            $display("FAIL mid_fill_start: m_re=%b expected 1", m_re);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (m_re !== 1'b0 || m_we !== 1'b0) begin
            fails++;
            $display("FAIL async_drop: m_re=%b m_we=%b expected 0 0", m_re, m_we);
        end
        cpu_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nr = n_rd;
        cpu_access(16'h0040, 1'b0, 16'h0, rd, cyc);
        tests++;
        if (cyc != 6 || n_rd != nr + 1 || rd !== 16'h0001) begin
            fails++;
            $display("FAIL miss_after_reset: cyc=%0d new_reads=%0d data=%h expected 6 1 0001", cyc, n_rd - nr, rd);
        end
        check_stats("reset_mid_fill", 16'd1, 16'd1);
    endtask

    task automatic test_saturation();
`ifdef NWAY_WB_CACHE_STATS_EN
        logic [15:0] rd;
        int cyc;
        apply_reset();
        cpu_access(16'h0040, 1'b0, 16'h0, rd, cyc);
        @(negedge clk);
        cpu_addr = 16'h0040;
        cpu_re = 1'b1;
        repeat (70000) @(negedge clk);
        cpu_re = 1'b0;
        check_stats("saturation", 16'hFFFF, 16'd1);
`else
        apply_reset();
        @(negedge clk);
        cpu_addr = 16'h0040;
        cpu_re = 1'b1;
        repeat (20) @(negedge clk);
        cpu_re = 1'b0;
        repeat (10) @(negedge clk);
        check_stats("stats_tied", 16'd0, 16'd0);
`endif
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_reset_mid_fill();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
